// File: rtl/cim_temp_mem_arbiter_if.sv
// Request, response and macro-side signals of the CiM temp-result storage
// arbiter. The slave modport faces the arbiter. The master modport faces the
// requesters and the storage macro.
interface cim_temp_mem_arbiter_if #(
  parameter int N_STORAGE = 22,
  parameter int DEPTH     = 848,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int NUM_SRC   = 7
);
  logic [NUM_SRC-1:0]                 read_req_src;
  logic [NUM_SRC-1:0]                 write_req_src;
  logic [NUM_SRC-1:0][ADDR_W-1:0]     addr_table;
  logic [NUM_SRC-1:0][N_STORAGE-1:0]  write_data;

  logic                               mem_en;
  logic                               mem_we;
  logic [ADDR_W-1:0]                  mem_addr;
  logic [N_STORAGE-1:0]               mem_wdata;
  logic [N_STORAGE-1:0]               mem_rdata;

  logic [N_STORAGE-1:0]               read_data;
  logic                               read_valid;
  logic [2:0]                         read_src;
  logic                               read_stall;
  logic                               err_multi_src;
  logic                               err_overflow;

  modport slave (
    input  read_req_src, write_req_src, addr_table, write_data, mem_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
           read_data, read_valid, read_src, read_stall,
           err_multi_src, err_overflow
  );

  modport master (
    output read_req_src, write_req_src, addr_table, write_data, mem_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
           read_data, read_valid, read_src, read_stall,
           err_multi_src, err_overflow
  );
endinterface

// File: rtl/cim_temp_mem_arbiter.sv
// Arbiter for the single-port CiM temp-result storage macro. Writes win over
// reads. A read that collides with a write, or with the draining of the
// pending buffer, is parked in a one-entry buffer. Read data comes back two
// cycles after issue, tagged with the owning source.
module cim_temp_mem_arbiter #(
  parameter int N_STORAGE = 22,
  parameter int DEPTH     = 848,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int NUM_SRC   = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cim_temp_mem_arbiter_if.slave   bus
);

  // Lowest set bit wins.
  function automatic logic [2:0] lowest_idx(input logic [NUM_SRC-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = 3'(i);
    end
  endfunction

  function automatic logic more_than_one(input logic [NUM_SRC-1:0] v);
    more_than_one = (v & (v - NUM_SRC'(1))) != '0;
  endfunction

  logic                 rd_any, wr_any;
  logic [2:0]           rd_idx, wr_idx;
  logic                 multi_src;

  logic                 pend_full;
  logic [ADDR_W-1:0]    pend_addr;
  logic [2:0]           pend_src;

  logic                 issue_rd;
  logic [2:0]           issue_src;
  logic                 pend_load, pend_clear, rd_drop;

  logic                 mem_en_c, mem_we_c;
  logic [ADDR_W-1:0]    mem_addr_c;
  logic [N_STORAGE-1:0] mem_wdata_c;

  logic                 vld_p1;
  logic [2:0]           src_p1;
  logic                 vld_p2;
  logic [N_STORAGE-1:0] data_p2;
  logic [2:0]           src_p2;

  logic                 err_multi_q, err_ovf_q;

  assign rd_any    = |bus.read_req_src;
  assign wr_any    = |bus.write_req_src;
  assign rd_idx    = lowest_idx(bus.read_req_src);
  assign wr_idx    = lowest_idx(bus.write_req_src);
  assign multi_src = more_than_one(bus.read_req_src) | more_than_one(bus.write_req_src);

  // Stage p0: pick write > pending read > new read and drive the macro.
  // Outputs are held quiet while reset is asserted.
  always_comb begin
    mem_en_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    issue_rd    = 1'b0;
    issue_src   = '0;
    pend_load   = 1'b0;
    pend_clear  = 1'b0;
    rd_drop     = 1'b0;
    if (rst_n) begin
      if (wr_any) begin
        mem_en_c    = 1'b1;
        mem_we_c    = 1'b1;
        mem_addr_c  = bus.addr_table[wr_idx];
        mem_wdata_c = bus.write_data[wr_idx];
        if (rd_any) begin
          if (pend_full) rd_drop   = 1'b1;
          else           pend_load = 1'b1;
        end
      end else if (pend_full) begin
        mem_en_c   = 1'b1;
        mem_addr_c = pend_addr;
        issue_rd   = 1'b1;
        issue_src  = pend_src;
        pend_clear = 1'b1;
        pend_load  = rd_any;
      end else if (rd_any) begin
        mem_en_c   = 1'b1;
        mem_addr_c = bus.addr_table[rd_idx];
        issue_rd   = 1'b1;
        issue_src  = rd_idx;
      end
    end
  end

  // Pending-read occupancy: a refill in the drain cycle keeps it full.
  always_ff @(posedge clk) begin
    if (!rst_n)          pend_full <= 1'b0;
    else if (pend_load)  pend_full <= 1'b1;
    else if (pend_clear) pend_full <= 1'b0;
  end

  // Pending-read address and tag; only meaningful while pend_full is set.
  always_ff @(posedge clk) begin
    if (pend_load) begin
      pend_addr <= bus.addr_table[rd_idx];
      pend_src  <= rd_idx;
    end
  end

  // Sticky protocol-violation flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_multi_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      if (multi_src) err_multi_q <= 1'b1;
      if (rd_drop)   err_ovf_q   <= 1'b1;
    end
  end

  // Stage p1: macro is reading; carry the valid and the tag alongside.
  always_ff @(posedge clk) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= issue_rd;
    src_p1 <= issue_src;
  end

  // Stage p2: register the macro data and the tag for the requester.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      src_p2  <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_p2 <= bus.mem_rdata;
        src_p2  <= src_p1;
      end
    end
  end

  assign bus.mem_en        = mem_en_c;
  assign bus.mem_we        = mem_we_c;
  assign bus.mem_addr      = mem_addr_c;
  assign bus.mem_wdata     = mem_wdata_c;
  assign bus.read_valid    = vld_p2;
  assign bus.read_data     = data_p2;
  assign bus.read_src      = src_p2;
  assign bus.read_stall    = pend_full;
  assign bus.err_multi_src = err_multi_q;
  assign bus.err_overflow  = err_ovf_q;

endmodule
